ysyx_2022040010_sbuf: RTL and testbench

Store buffer for the ysyx_2022040010 core; the write-side counterpart of the MEM-stage load path. It accepts store requests (sb/sh/sw/sd) from EX, aligns each to a 64-bit doubleword lane with a byte mask, and queues it in a small FIFO. It drains entries to the data SRAM write port under a we/ack handshake. It also flags load hazards against pending stores and supports a full drain for fence.

---
 rtl/ysyx_2022040010_sbuf.sv | 159 +++++++++++++++
 tb/tb_ysyx_2022040010_sbuf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_sbuf.sv
// Store buffer: aligns sb/sh/sw/sd requests to a doubleword lane with a byte
// mask, queues them in a small FIFO and drains them to the data SRAM write
// port. Also flags loads that hit a pending store and supports fence drain.
module ysyx_2022040010_sbuf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [3:0]               st_op,
  input  logic [63:0]              st_addr,
  input  logic [63:0]              st_data,
  output logic                     st_misalign,
  output logic                     dsram_we,
  output logic [63:0]              dsram_addr,
  output logic [63:0]              dsram_wdata,
  output logic [7:0]               dsram_wmask,
  input  logic                     dsram_ack,
  input  logic [63:0]              ld_chk_addr,
  input  logic                     ld_chk_valid,
  output logic                     ld_hazard,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic          done_next;

  // Entries keep only the doubleword line; the byte offset lives in the mask.
  logic [60:0]   ent_line [DEPTH];
  logic [63:0]   ent_data [DEPTH];
  logic [7:0]    ent_mask [DEPTH];
  logic [PW-1:0] head, tail;

  logic [2:0]    off;
  logic          op_ok, misal;
  logic [7:0]    mask;
  logic [63:0]   wdata;
  logic          accept, enq, deq;
  logic [PW-1:0] rel;
  logic          ld_off_unused;

  assign ld_off_unused = ^ld_chk_addr[2:0];

  // Decode the store size into lane mask, replicated data and alignment fault.
  always_comb begin
    off   = st_addr[2:0];
    op_ok = 1'b1;
    misal = 1'b0;
    mask  = '0;
    wdata = '0;
    case (st_op)
      4'b1000: begin
        mask  = 8'h01 << off;
        wdata = {8{st_data[7:0]}};
      end
      4'b0100: begin
        mask  = 8'h03 << off;
        wdata = {4{st_data[15:0]}};
        misal = off[0];
      end
      4'b0010: begin
        mask  = 8'h0F << off;
        wdata = {2{st_data[31:0]}};
        misal = (off[1:0] != 2'b00);
      end
      4'b0001: begin
        mask  = 8'hFF;
        wdata = st_data;
        misal = (off != 3'b000);
      end
      default: op_ok = 1'b0;
    endcase
  end

  assign st_ready    = rst & (count < CW'(DEPTH)) & (state == RUN);
  assign accept      = st_valid & st_ready & op_ok;
  assign enq         = accept & ~misal;
  assign dsram_we    = (count != '0);
  assign deq         = dsram_we & dsram_ack;
  assign dsram_addr  = {ent_line[head], 3'b000};
  assign dsram_wdata = ent_data[head];
  assign dsram_wmask = ent_mask[head];

  // Entry storage; needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_line[tail] <= st_addr[63:3];
      ent_data[tail] <= wdata;
      ent_mask[tail] <= mask;
    end
  end

  // Pointers, occupancy and the misalign pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      st_misalign <= 1'b0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      st_misalign <= accept & misal;
    end
  end

  // Load hazard: an entry is live when its distance from head is below count.
  always_comb begin
    ld_hazard = 1'b0;
    rel       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - head;
      if (({1'b0, rel} < count) && (ent_line[i] == ld_chk_addr[63:3]))
        ld_hazard = 1'b1;
    end
    ld_hazard = ld_hazard & ld_chk_valid;
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      state      <= state_next;
      drain_done <= done_next;
    end
  end

  // Drain FSM next state: fence blocks new stores until the FIFO is empty.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      RUN: if (drain_req) state_next = DRAIN;
      DRAIN: begin
        if (count == '0) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_ysyx_2022040010_sbuf.sv
// Scoreboard bench for the store buffer: a queue-based reference model
// predicts every SRAM write and the per-cycle status outputs.
module tb_ysyx_2022040010_sbuf;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, st_valid, st_ready, st_misalign;
  logic [3:0]  st_op;
  logic [63:0] st_addr, st_data;
  logic        dsram_we, dsram_ack;
  logic [63:0] dsram_addr, dsram_wdata;
  logic [7:0]  dsram_wmask;
  logic [63:0] ld_chk_addr;
  logic        ld_chk_valid, ld_hazard, drain_req, drain_done;
  logic [2:0]  count;

  always #5 clk = ~clk;

  ysyx_2022040010_sbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_misalign(st_misalign), .dsram_we(dsram_we), .dsram_addr(dsram_addr),
    .dsram_wdata(dsram_wdata), .dsram_wmask(dsram_wmask), .dsram_ack(dsram_ack),
    .ld_chk_addr(ld_chk_addr), .ld_chk_valid(ld_chk_valid), .ld_hazard(ld_hazard),
    .drain_req(drain_req), .drain_done(drain_done), .count(count)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } wr_t;

  wr_t exp_q[$];   // scoreboard: writes the SRAM port must still produce
  wr_t mq[$];      // model FIFO contents
  int  n_vec = 0, n_err = 0;
  bit  mdrain = 0, exp_mis = 0, exp_done = 0;

  localparam logic [3:0] SB = 4'b1000, SH = 4'b0100, SW = 4'b0010, SD = 4'b0001;

  function automatic int unsigned op_size(logic [3:0] op);
    case (op)
      SB: return 1;
      SH: return 2;
      SW: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic wr_t make_wr(logic [3:0] op, logic [63:0] a, logic [63:0] d);
    wr_t w;
    int unsigned sz = op_size(op);
    int unsigned o  = int'(a[2:0]);
    w.addr = {a[63:3], 3'b000};
    w.mask = 8'(((1 << sz) - 1) << o);
    for (int k = 0; k < 8; k++) w.data[8*k +: 8] = d[8*(k % sz) +: 8];
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then compare the status outputs shortly after the edge.
  task automatic step();
    bit ready, ok, acc, mis, ret, hz;
    int unsigned pre, sz;
    wr_t w;
    @(posedge clk);
    pre   = mq.size();
    ready = rst && (pre < DEPTH) && !mdrain;
    ok    = st_op inside {SB, SH, SW, SD};
    acc   = st_valid && ready && ok;
    sz    = op_size(st_op);
    mis   = acc && ((int'(st_addr[2:0]) % sz) != 0);
    ret   = (pre != 0) && dsram_ack;
    exp_done = 0;
    exp_mis  = 0;
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      mdrain = 0;
    end else begin
      if (mdrain) begin
        if (pre == 0) begin
          exp_done = 1;
          mdrain   = 0;
        end
      end else if (drain_req) mdrain = 1;
      if (ret) void'(mq.pop_front());
      if (acc && !mis) begin
        w = make_wr(st_op, st_addr, st_data);
        mq.push_back(w);
        exp_q.push_back(w);
      end
      exp_mis = acc && mis;
    end
    #1;
    hz = 0;
    foreach (mq[i]) if (mq[i].addr[63:3] == ld_chk_addr[63:3]) hz = 1;
    hz = hz && ld_chk_valid;
    chk("count", 64'(count), 64'(mq.size()));
    chk("dsram_we", 64'(dsram_we), 64'(mq.size() != 0));
    chk("st_ready", 64'(st_ready), 64'(rst && mq.size() < DEPTH && !mdrain));
    chk("ld_hazard", 64'(ld_hazard), 64'(hz));
    chk("st_misalign", 64'(st_misalign), 64'(exp_mis));
    chk("drain_done", 64'(drain_done), 64'(exp_done));
  endtask

  task automatic store(logic [3:0] op, logic [63:0] a, logic [63:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
    step();
    st_valid = 1'b0;
  endtask

  // Monitor: every retired SRAM write is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    if (rst === 1'b1 && dsram_we === 1'b1 && dsram_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL retire_unexpected: got addr %h with no write expected", dsram_addr);
      end else begin
        w = exp_q.pop_front();
        chk("dsram_addr", dsram_addr, w.addr);
        chk("dsram_wdata", dsram_wdata, w.data);
        chk("dsram_wmask", 64'(dsram_wmask), 64'(w.mask));
      end
    end
  end

  initial begin
    int unsigned r;
    rst = 1'b0; st_valid = 1'b0; st_op = '0; st_addr = '0; st_data = '0;
    dsram_ack = 1'b0; ld_chk_addr = '0; ld_chk_valid = 1'b0; drain_req = 1'b0;
    step(); step();
    rst = 1'b1;
    step();

    // single byte store, retired immediately
    dsram_ack = 1'b1;
    store(SB, 64'h8000_0005, 64'h1122_3344_5566_77AB);
    step(); step();

    // word then halfword, retired in order
    dsram_ack = 1'b0;
    store(SW, 64'h1004, 64'h1234_5678);
    store(SH, 64'h1002, 64'hBEEF);
    dsram_ack = 1'b1;
    step(); step(); step();

    // misaligned doubleword is dropped
    store(SD, 64'h1001, 64'hDEAD_BEEF_0000_0001);
    step();

    // fill past capacity, release, then wrap the pointers
    dsram_ack = 1'b0;
    for (int i = 0; i < 5; i++) store(SD, 64'h3000 + 64'(8 * i), 64'hA000 + 64'(i));
    dsram_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    dsram_ack = 1'b0;
    for (int i = 0; i < 4; i++) store(SD, 64'h4000 + 64'(8 * i), 64'hB000 + 64'(i));
    dsram_ack = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // load hazard against a pending doubleword
    dsram_ack = 1'b0;
    store(SD, 64'h2000, 64'h5555);
    ld_chk_valid = 1'b1;
    ld_chk_addr  = 64'h2006;
    step();
    ld_chk_addr  = 64'h2008;
    step();
    ld_chk_addr  = 64'h2000;
    dsram_ack = 1'b1;
    step(); step();
    ld_chk_valid = 1'b0;

    // fence drain with ack every other cycle and stores offered throughout
    dsram_ack = 1'b0;
    for (int i = 0; i < 3; i++) store(SW, 64'h5000 + 64'(4 * i), 64'hC0 + 64'(i));
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dsram_ack = i[0];
      store(SB, 64'h6000 + 64'(i), 64'(i));
    end
    dsram_ack = 1'b0;
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    step(); step();

    // reset in the middle of a drain
    store(SD, 64'h7000, 64'h1);
    store(SD, 64'h7008, 64'h2);
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step(); step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      st_valid  = $urandom_range(0, 1) != 0;
      r         = $urandom_range(0, 9);
      st_op     = (r < 8) ? 4'(1 << (r % 4)) : ((r == 8) ? 4'b0000 : 4'b0110);
      st_addr   = 64'h8000_0000 + 64'($urandom_range(0, 3) << 3);
      if ($urandom_range(0, 1) != 0) st_addr[2:0] = 3'($urandom_range(0, 7));
      else st_addr[2:0] = 3'((r % 4 == 0) ? 0 : ($urandom_range(0, 7) & ~(op_size(st_op) - 1)));
      st_data   = {$urandom, $urandom};
      dsram_ack = rst && ($urandom_range(0, 1) != 0);
      drain_req = ($urandom_range(0, 29) == 0);
      ld_chk_valid = $urandom_range(0, 1) != 0;
      ld_chk_addr  = 64'h8000_0000 + 64'($urandom_range(0, 5) << 3) + 64'($urandom_range(0, 7));
      step();
    end

    // flush everything and confirm the scoreboard drained with the model
    rst = 1'b1; st_valid = 1'b0; drain_req = 1'b0; ld_chk_valid = 1'b0;
    dsram_ack = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("scoreboard_left", 64'(exp_q.size()), 64'(mq.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
